// File: rtl/demux2_fifo.sv
// demux2_fifo: single-clock FIFO holding one output channel of demux2_stream.
//
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   push         write push_data this cycle; ignored while full
//   push_data    word to store
//   full         no free entry (registered state only)
//   pop          remove the head entry this cycle; ignored while empty
//   head_data    oldest stored word; stale when empty, zero after reset
//   empty        no stored word (registered state only)
module demux2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the addresses coincide.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head output reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demultiplexer. Each accepted input
// word is routed by SEL into one of two per-channel FIFOs, so a stalled
// consumer on one channel never blocks or reorders the other.
//
// Ports:
//   CLK, RST                  clock (rising edge), synchronous active-high reset
//   In_Valid / In_Ready       input handshake; In_Ready depends only on SEL,
//                             RST and registered FIFO state
//   SEL                       destination channel for the current input word
//   Dato                      input word
//   Out0_Valid/Ready/Dato     channel 0 output stream
//   Out1_Valid/Ready/Dato     channel 1 output stream
//   Cnt0, Cnt1                words accepted per channel since reset (wrapping)
module demux2_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             SEL,
  input  logic [WIDTH-1:0] Dato,
  output logic             Out0_Valid,
  input  logic             Out0_Ready,
  output logic [WIDTH-1:0] Out0_Dato,
  output logic             Out1_Valid,
  input  logic             Out1_Ready,
  output logic [WIDTH-1:0] Out1_Dato,
  output logic [CNTW-1:0]  Cnt0,
  output logic [CNTW-1:0]  Cnt1
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic accept;

  // No path from Out*_Ready: a pop freeing space only raises In_Ready after
  // the edge that performed it.
  assign In_Ready = !RST && !(SEL ? full1 : full0);
  assign accept   = In_Valid && In_Ready;
  assign push0    = accept && !SEL;
  assign push1    = accept && SEL;

  assign Out0_Valid = !empty0;
  assign Out1_Valid = !empty1;

  demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (CLK),
    .rst       (RST),
    .push      (push0),
    .push_data (Dato),
    .full      (full0),
    .pop       (Out0_Ready),
    .head_data (Out0_Dato),
    .empty     (empty0)
  );

  demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (CLK),
    .rst       (RST),
    .push      (push1),
    .push_data (Dato),
    .full      (full1),
    .pop       (Out1_Ready),
    .head_data (Out1_Dato),
    .empty     (empty1)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      Cnt0 <= '0;
      Cnt1 <= '0;
    end else begin
      if (push0) Cnt0 <= Cnt0 + CNTW'(1);
      if (push1) Cnt1 <= Cnt1 + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_demux2_stream.sv
module tb_demux2_stream;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNTW  = 16;

  logic             CLK;
  logic             RST;
  logic             In_Valid;
  logic             In_Ready;
  logic             SEL;
  logic [WIDTH-1:0] Dato;
  logic             Out0_Valid, Out0_Ready;
  logic [WIDTH-1:0] Out0_Dato;
  logic             Out1_Valid, Out1_Ready;
  logic [WIDTH-1:0] Out1_Dato;
  logic [CNTW-1:0]  Cnt0, Cnt1;

  // Narrow-counter instance used only for the wrap check.
  logic             w_rst, w_valid, w_ready_in, w_sel;
  logic [WIDTH-1:0] w_dato;
  logic             w_out0_valid, w_out1_valid;
  logic [WIDTH-1:0] w_out0_dato, w_out1_dato;
  logic             w_out0_ready, w_out1_ready;
  logic [3:0]       w_cnt0, w_cnt1;

  int checks = 0;
  int errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready), .SEL(SEL), .Dato(Dato),
    .Out0_Valid(Out0_Valid), .Out0_Ready(Out0_Ready), .Out0_Dato(Out0_Dato),
    .Out1_Valid(Out1_Valid), .Out1_Ready(Out1_Ready), .Out1_Dato(Out1_Dato),
    .Cnt0(Cnt0), .Cnt1(Cnt1)
  );

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(4)) dut_w (
    .CLK(CLK), .RST(w_rst), .In_Valid(w_valid), .In_Ready(w_ready_in), .SEL(w_sel), .Dato(w_dato),
    .Out0_Valid(w_out0_valid), .Out0_Ready(w_out0_ready), .Out0_Dato(w_out0_dato),
    .Out1_Valid(w_out1_valid), .Out1_Ready(w_out1_ready), .Out1_Dato(w_out1_dato),
    .Cnt0(w_cnt0), .Cnt1(w_cnt1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Behavioural model: two queues of words plus two wrapping counters.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [CNTW-1:0]  m_cnt0, m_cnt1;
  bit               model_live = 0;

  always @(posedge CLK) begin
    bit pop0, pop1, push;
    if (RST) begin
      q0.delete();
      q1.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
      model_live = 1;
    end else if (model_live) begin
      pop0 = Out0_Ready && (q0.size() > 0);
      pop1 = Out1_Ready && (q1.size() > 0);
      push = In_Valid && ((SEL ? q1.size() : q0.size()) < DEPTH);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (push) begin
        if (SEL) begin
          q1.push_back(Dato);
          m_cnt1 = m_cnt1 + 1'b1;
        end else begin
          q0.push_back(Dato);
          m_cnt0 = m_cnt0 + 1'b1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (model_live) begin
      check("in_ready", In_Ready, !RST && ((SEL ? q1.size() : q0.size()) < DEPTH));
      check("out0_valid", Out0_Valid, q0.size() > 0);
      check("out1_valid", Out1_Valid, q1.size() > 0);
      if (q0.size() > 0) check("out0_dato", Out0_Dato, q0[0]);
      if (q1.size() > 0) check("out1_dato", Out1_Dato, q1[0]);
      check("cnt0", Cnt0, m_cnt0);
      check("cnt1", Cnt1, m_cnt1);
    end
  end

  initial begin
    RST = 1; In_Valid = 1; SEL = 0; Dato = '0; Out0_Ready = 0; Out1_Ready = 0;
    w_rst = 1; w_valid = 0; w_sel = 1; w_dato = '0; w_out0_ready = 1; w_out1_ready = 1;

    // Reset held for two edges with In_Valid high.
    @(negedge CLK);
    check("rst_in_ready", In_Ready, 0);
    tick();
    RST = 0; In_Valid = 0; w_rst = 0;
    @(negedge CLK);
    check("rst_out0_valid", Out0_Valid, 0);
    check("rst_out1_valid", Out1_Valid, 0);
    check("rst_cnt0", Cnt0, 0);
    check("rst_cnt1", Cnt1, 0);
    tick();

    // Routing.
    Out0_Ready = 1; Out1_Ready = 1;
    In_Valid = 1; SEL = 0; Dato = 32'hAAAA0001;
    tick();
    SEL = 1; Dato = 32'h55550002;
    @(negedge CLK);
    check("route_out0_valid", Out0_Valid, 1);
    check("route_out0_dato", Out0_Dato, 32'hAAAA0001);
    tick();
    In_Valid = 0;
    @(negedge CLK);
    check("route_out1_dato", Out1_Dato, 32'h55550002);
    check("route_cnt0", Cnt0, 1);
    check("route_cnt1", Cnt1, 1);
    tick();

    // Backpressure on channel 0.
    Out0_Ready = 0;
    In_Valid = 1; SEL = 0; Dato = 32'h11;
    tick();
    Dato = 32'h22;
    tick();
    Dato = 32'h33;
    @(negedge CLK);
    check("bp_full_in_ready", In_Ready, 0);
    tick();
    Out0_Ready = 1;
    @(negedge CLK);
    check("bp_head1", Out0_Dato, 32'h11);
    check("bp_still_stalled", In_Ready, 0);
    tick();
    @(negedge CLK);
    check("bp_ready_back", In_Ready, 1);
    check("bp_head2", Out0_Dato, 32'h22);
    tick();
    In_Valid = 0;
    @(negedge CLK);
    check("bp_head3", Out0_Dato, 32'h33);
    tick();
    @(negedge CLK);
    check("bp_drained", Out0_Valid, 0);

    // Independence: channel 0 full, channel 1 streams freely.
    Out0_Ready = 0; Out1_Ready = 1;
    In_Valid = 1; SEL = 0; Dato = 32'hC0;
    tick();
    Dato = 32'hC1;
    tick();
    SEL = 1;
    for (int i = 0; i < 4; i++) begin
      Dato = 32'hD0 + i;
      @(negedge CLK);
      check("ind_ready", In_Ready, 1);
      tick();
    end
    In_Valid = 0;
    @(negedge CLK);
    check("ind_ch0_head", Out0_Dato, 32'hC0);
    check("ind_ch0_valid", Out0_Valid, 1);
    check("ind_cnt1", Cnt1, 5);
    check("ind_cnt0", Cnt0, 6);
    Out0_Ready = 1;
    tick(); tick(); tick();

    // Reset mid-stream with words buffered on both channels.
    Out0_Ready = 0; Out1_Ready = 0;
    In_Valid = 1; SEL = 0; Dato = 32'hE0; tick();
    Dato = 32'hE1; tick();
    SEL = 1; Dato = 32'hF0; tick();
    Dato = 32'hF1; tick();
    RST = 1; SEL = 0; Dato = 32'hF2; Out0_Ready = 1;
    tick();
    RST = 0; In_Valid = 0; Out0_Ready = 0;
    @(negedge CLK);
    check("mid_rst_out0_valid", Out0_Valid, 0);
    check("mid_rst_out1_valid", Out1_Valid, 0);
    check("mid_rst_cnt0", Cnt0, 0);
    check("mid_rst_cnt1", Cnt1, 0);
    In_Valid = 1; SEL = 0; Dato = 32'h12345678;
    tick();
    In_Valid = 0;
    @(negedge CLK);
    check("post_rst_valid", Out0_Valid, 1);
    check("post_rst_dato", Out0_Dato, 32'h12345678);
    Out0_Ready = 1;
    tick();

    // Counter wrap on the 4-bit instance: 17 pushes to channel 1.
    w_valid = 1;
    for (int i = 0; i < 17; i++) begin
      w_dato = i;
      tick();
    end
    w_valid = 0;
    @(negedge CLK);
    check("wrap_cnt1", w_cnt1, 1);
    check("wrap_cnt0", w_cnt0, 0);

    // Randomized traffic, occasional resets, varying backpressure.
    for (int i = 0; i < 3000; i++) begin
      RST        = ($urandom_range(0, 199) == 0);
      In_Valid   = ($urandom_range(0, 3) != 0);
      SEL        = $urandom_range(0, 1);
      Dato       = $urandom;
      Out0_Ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      Out1_Ready = (i % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end
    RST = 0; In_Valid = 0; Out0_Ready = 1; Out1_Ready = 1;
    tick(); tick(); tick();
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
